// File: rtl/branch_predict_queue.sv
// rtl/branch_predict_queue.sv - in-order branch prediction tracking queue; optional counters under BPQ_STATS_EN
module branch_predict_queue #(
    parameter int DEPTH    = 16,
    parameter int PTR_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_valid_i,
    output logic                alloc_ready_o,
    input  logic [31:0]         alloc_pc_i,
    input  logic                alloc_gshare_pred_i,
    input  logic                alloc_bimodal_pred_i,
    input  logic                alloc_select_gshare_i,
    output logic [PTR_BITS-1:0] alloc_tag_o,
    input  logic                resolve_valid_i,
    input  logic [PTR_BITS-1:0] resolve_tag_i,
    input  logic                resolve_taken_i,
    input  logic                flush_valid_i,
    input  logic [PTR_BITS-1:0] flush_tag_i,
    input  logic                flush_all_i,
    output logic                mispredict_o,
    output logic [PTR_BITS-1:0] mispredict_tag_o,
    output logic                update_valid_o,
    output logic [31:0]         update_pc_o,
    output logic                update_taken_o,
    output logic                update_gshare_correct_o,
    output logic                update_bimodal_correct_o,
    output logic                empty_o
`ifdef BPQ_STATS_EN
    ,
    output logic [31:0]         stat_retired_o,
    output logic [31:0]         stat_mispredict_o,
    output logic [31:0]         stat_sel_gshare_o
`endif
);

    localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS+1)'(DEPTH);
    localparam logic [PTR_BITS:0] CNT_ONE    = (PTR_BITS+1)'(1);

    logic [PTR_BITS-1:0] head_q;
    logic [PTR_BITS-1:0] tail_q;
    logic [PTR_BITS:0]   count_q;
    logic [PTR_BITS:0]   count_d;

    logic [DEPTH-1:0]    valid_q;
    logic [DEPTH-1:0]    resolved_q;
    logic [DEPTH-1:0]    taken_q;
    logic [DEPTH-1:0]    gpred_q;
    logic [DEPTH-1:0]    bpred_q;
    logic [DEPTH-1:0]    sel_q;
    logic [31:0]         pc_q [DEPTH];

    logic                alloc_fire;
    logic                retire_fire;
    logic                flush_fire;
    logic                resolve_fire;
    logic                resolve_final_pred;
    logic                resolve_mis;
    logic [PTR_BITS-1:0] flush_age;
    logic [PTR_BITS-1:0] entry_age;
    logic [DEPTH-1:0]    squash_mask;

    assign alloc_ready_o = !rst && !flush_valid_i && !flush_all_i && (count_q < FULL_COUNT);
    assign alloc_fire    = alloc_valid_i && alloc_ready_o;
    assign alloc_tag_o   = tail_q;
    assign empty_o       = (count_q == '0);

    // The head retires off registered state only, so a same-cycle resolve never retires
    assign retire_fire = !flush_all_i && valid_q[head_q] && resolved_q[head_q];

    // A flush to a tag that holds no live entry is dropped entirely
    assign flush_fire = !flush_all_i && flush_valid_i && valid_q[flush_tag_i];
    assign flush_age  = flush_tag_i - head_q;

    // Age relative to head identifies entries younger than the surviving flush tag
    always_comb begin
        squash_mask = '0;
        entry_age   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_age      = PTR_BITS'(i) - head_q;
            squash_mask[i] = flush_fire && valid_q[i] && (entry_age > flush_age);
        end
    end

    assign resolve_fire = !flush_all_i && resolve_valid_i
                        && valid_q[resolve_tag_i] && !resolved_q[resolve_tag_i]
                        && !squash_mask[resolve_tag_i];
    assign resolve_final_pred = sel_q[resolve_tag_i] ? gpred_q[resolve_tag_i]
                                                     : bpred_q[resolve_tag_i];
    assign resolve_mis = resolve_taken_i ^ resolve_final_pred;

    // Occupancy after this cycle's flush, allocation and retirement
    always_comb begin
        count_d = count_q;
        if (flush_fire) begin
            count_d = {1'b0, flush_age} + CNT_ONE;
        end else if (alloc_fire) begin
            count_d = count_q + CNT_ONE;
        end
        if (retire_fire) begin
            count_d = count_d - CNT_ONE;
        end
    end

    // Head, tail and occupancy registers
    always_ff @(posedge clk) begin
        if (rst || flush_all_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_d;
            if (retire_fire) begin
                head_q <= head_q + 1'b1;
            end
            if (flush_fire) begin
                tail_q <= flush_tag_i + 1'b1;
            end else if (alloc_fire) begin
                tail_q <= tail_q + 1'b1;
            end
        end
    end

    // Per-entry valid and resolved flags
    always_ff @(posedge clk) begin
        if (rst || flush_all_i) begin
            valid_q    <= '0;
            resolved_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (retire_fire && (head_q == PTR_BITS'(i))) begin
                    valid_q[i] <= 1'b0;
                end
                if (squash_mask[i]) begin
                    valid_q[i] <= 1'b0;
                end
                if (alloc_fire && (tail_q == PTR_BITS'(i))) begin
                    valid_q[i]    <= 1'b1;
                    resolved_q[i] <= 1'b0;
                end
                if (resolve_fire && (resolve_tag_i == PTR_BITS'(i))) begin
                    resolved_q[i] <= 1'b1;
                end
            end
        end
    end

    // Entry payload: predictions captured at allocation, direction at resolution
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            pc_q[tail_q]    <= alloc_pc_i;
            gpred_q[tail_q] <= alloc_gshare_pred_i;
            bpred_q[tail_q] <= alloc_bimodal_pred_i;
            sel_q[tail_q]   <= alloc_select_gshare_i;
        end
        if (resolve_fire) begin
            taken_q[resolve_tag_i] <= resolve_taken_i;
        end
    end

    // Registered mispredict report and retirement training packet
    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict_o             <= 1'b0;
            mispredict_tag_o         <= '0;
            update_valid_o           <= 1'b0;
            update_pc_o              <= '0;
            update_taken_o           <= 1'b0;
            update_gshare_correct_o  <= 1'b0;
            update_bimodal_correct_o <= 1'b0;
        end else begin
            mispredict_o <= resolve_fire && resolve_mis;
            if (resolve_fire) begin
                mispredict_tag_o <= resolve_tag_i;
            end
            update_valid_o <= retire_fire;
            if (retire_fire) begin
                update_pc_o              <= pc_q[head_q];
                update_taken_o           <= taken_q[head_q];
                update_gshare_correct_o  <= (gpred_q[head_q] == taken_q[head_q]);
                update_bimodal_correct_o <= (bpred_q[head_q] == taken_q[head_q]);
            end
        end
    end

`ifdef BPQ_STATS_EN
    // Free-running event counters; flushes leave them untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_retired_o    <= '0;
            stat_mispredict_o <= '0;
            stat_sel_gshare_o <= '0;
        end else begin
            if (retire_fire) begin
                stat_retired_o <= stat_retired_o + 32'd1;
            end
            if (resolve_fire && resolve_mis) begin
                stat_mispredict_o <= stat_mispredict_o + 32'd1;
            end
            if (retire_fire && sel_q[head_q]) begin
                stat_sel_gshare_o <= stat_sel_gshare_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predict_queue.sv
// tb/tb_branch_predict_queue.sv - directed and randomized checks against a queue-based reference model
module tb_branch_predict_queue;

    localparam int DEPTH = 16;
    localparam int PB    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          alloc_valid;
    logic          alloc_ready;
    logic [31:0]   alloc_pc;
    logic          alloc_g;
    logic          alloc_b;
    logic          alloc_sel;
    logic [PB-1:0] alloc_tag;
    logic          resolve_valid;
    logic [PB-1:0] resolve_tag;
    logic          resolve_taken;
    logic          flush_valid;
    logic [PB-1:0] flush_tag;
    logic          flush_all;
    logic          mis;
    logic [PB-1:0] mis_tag;
    logic          uv;
    logic [31:0]   upc;
    logic          ut;
    logic          ugc;
    logic          ubc;
    logic          empty;
`ifdef BPQ_STATS_EN
    logic [31:0]   stat_ret;
    logic [31:0]   stat_mis;
    logic [31:0]   stat_sel;
`endif

    branch_predict_queue #(.DEPTH(DEPTH), .PTR_BITS(PB)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .alloc_valid_i            (alloc_valid),
        .alloc_ready_o            (alloc_ready),
        .alloc_pc_i               (alloc_pc),
        .alloc_gshare_pred_i      (alloc_g),
        .alloc_bimodal_pred_i     (alloc_b),
        .alloc_select_gshare_i    (alloc_sel),
        .alloc_tag_o              (alloc_tag),
        .resolve_valid_i          (resolve_valid),
        .resolve_tag_i            (resolve_tag),
        .resolve_taken_i          (resolve_taken),
        .flush_valid_i            (flush_valid),
        .flush_tag_i              (flush_tag),
        .flush_all_i              (flush_all),
        .mispredict_o             (mis),
        .mispredict_tag_o         (mis_tag),
        .update_valid_o           (uv),
        .update_pc_o              (upc),
        .update_taken_o           (ut),
        .update_gshare_correct_o  (ugc),
        .update_bimodal_correct_o (ubc),
        .empty_o                  (empty)
`ifdef BPQ_STATS_EN
        ,
        .stat_retired_o           (stat_ret),
        .stat_mispredict_o        (stat_mis),
        .stat_sel_gshare_o        (stat_sel)
`endif
    );

    typedef struct {
        logic [PB-1:0] tag;
        logic [31:0]   pc;
        bit            g;
        bit            b;
        bit            sel;
        bit            res;
        bit            taken;
    } ent_t;

    // Reference model: in-flight branches oldest first, plus expected registered outputs
    ent_t          mq[$];
    int            m_tail;
    bit            e_mis;
    logic [PB-1:0] e_mis_tag;
    bit            e_uv;
    logic [31:0]   e_upc;
    bit            e_ut;
    bit            e_ugc;
    bit            e_ubc;
    int            m_ret;
    int            m_misc;
    int            m_sel;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic idle_inputs();
        alloc_valid   = 1'b0;
        alloc_pc      = '0;
        alloc_g       = 1'b0;
        alloc_b       = 1'b0;
        alloc_sel     = 1'b0;
        resolve_valid = 1'b0;
        resolve_tag   = '0;
        resolve_taken = 1'b0;
        flush_valid   = 1'b0;
        flush_tag     = '0;
        flush_all     = 1'b0;
    endtask

    // Advance the model by one clock using the currently driven inputs, then clock the DUT
    task automatic cycle();
        bit   retire;
        bit   ready;
        int   p;
        int   r;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_tail = 0; e_mis = 0; e_mis_tag = '0; e_uv = 0; e_upc = '0;
            e_ut = 0; e_ugc = 0; e_ubc = 0; m_ret = 0; m_misc = 0; m_sel = 0;
        end else if (flush_all) begin
            mq.delete();
            m_tail = 0; e_mis = 0; e_uv = 0;
        end else begin
            retire = (mq.size() > 0) && mq[0].res;
            ready  = !flush_valid && (mq.size() < DEPTH);
            p = -1;
            r = -1;
            if (flush_valid) foreach (mq[k]) if (mq[k].tag == flush_tag) p = k;
            if (resolve_valid) foreach (mq[k]) if (mq[k].tag == resolve_tag) r = k;
            e_mis = 0;
            if (r >= 0 && !mq[r].res && !(p >= 0 && r > p)) begin
                mq[r].res   = 1'b1;
                mq[r].taken = resolve_taken;
                e_mis       = resolve_taken != (mq[r].sel ? mq[r].g : mq[r].b);
                e_mis_tag   = resolve_tag;
                if (e_mis) m_misc++;
            end
            if (p >= 0) begin
                while (mq.size() > p + 1) void'(mq.pop_back());
                m_tail = (int'(flush_tag) + 1) % DEPTH;
            end
            e_uv = retire;
            if (retire) begin
                e     = mq.pop_front();
                e_upc = e.pc;
                e_ut  = e.taken;
                e_ugc = (e.g == e.taken);
                e_ubc = (e.b == e.taken);
                m_ret++;
                if (e.sel) m_sel++;
            end
            if (alloc_valid && ready) begin
                e.tag = PB'(m_tail); e.pc = alloc_pc; e.g = alloc_g; e.b = alloc_b;
                e.sel = alloc_sel; e.res = 0; e.taken = 0;
                mq.push_back(e);
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic alloc_one(input logic [31:0] pc, input bit g, input bit b, input bit sel);
        alloc_valid = 1'b1; alloc_pc = pc; alloc_g = g; alloc_b = b; alloc_sel = sel;
        cycle();
        alloc_valid = 1'b0;
    endtask

    task automatic resolve_one(input logic [PB-1:0] tag, input bit taken);
        resolve_valid = 1'b1; resolve_tag = tag; resolve_taken = taken;
        cycle();
        resolve_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        n_checks++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in_rst: got %0b expected 0", alloc_ready); end
        rst = 1'b0;
        #1;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %0b expected 1", empty); end
        n_checks++; if ({mis, mis_tag} !== '0) begin n_fail++; $display("FAIL reset_mispredict: got %0b/%0d expected 0/0", mis, mis_tag); end
        n_checks++; if ({uv, upc, ut, ugc, ubc} !== '0) begin n_fail++; $display("FAIL reset_update: got v=%0b pc=%h expected all 0", uv, upc); end
        n_checks++; if (alloc_tag !== '0) begin n_fail++; $display("FAIL reset_tag: got %0d expected 0", alloc_tag); end
        n_checks++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b expected 1", alloc_ready); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            alloc_valid = 1'b1; alloc_pc = $urandom; alloc_g = 1'($urandom);
            alloc_b = 1'($urandom); alloc_sel = 1'($urandom);
            #1;
            n_checks++; if (alloc_tag !== PB'(i)) begin n_fail++; $display("FAIL fill_tag: got %0d expected %0d", alloc_tag, i); end
            n_checks++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready: got %0b expected 1 at %0d", alloc_ready, i); end
            cycle();
        end
        n_checks++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %0b expected 0", alloc_ready); end
        n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL full_empty: got %0b expected 0", empty); end
        cycle();
        alloc_valid = 1'b0;
        #1;
        n_checks++; if (alloc_tag !== PB'(0) || alloc_ready !== 1'b0) begin n_fail++; $display("FAIL full_reject: got tag %0d ready %0b expected 0/0", alloc_tag, alloc_ready); end
    endtask

    task automatic test_mispredict();
        do_reset();
        alloc_one(32'h100, 1'b1, 1'b0, 1'b0);
        resolve_one(PB'(0), 1'b1);
        n_checks++; if (mis !== 1'b1 || mis_tag !== PB'(0)) begin n_fail++; $display("FAIL mis_report: got %0b/%0d expected 1/0", mis, mis_tag); end
        n_checks++; if (uv !== 1'b0) begin n_fail++; $display("FAIL mis_early_update: got %0b expected 0", uv); end
        cycle();
        n_checks++; if (uv !== 1'b1 || upc !== 32'h100) begin n_fail++; $display("FAIL mis_update: got v=%0b pc=%h expected 1/100", uv, upc); end
        n_checks++; if ({ut, ugc, ubc} !== 3'b110) begin n_fail++; $display("FAIL mis_train: got %b expected 110", {ut, ugc, ubc}); end
        n_checks++; if (mis !== 1'b0) begin n_fail++; $display("FAIL mis_clear: got %0b expected 0", mis); end
    endtask

    task automatic test_out_of_order();
        logic [31:0] pcs [3];
        pcs[0] = 32'h200; pcs[1] = 32'h204; pcs[2] = 32'h208;
        do_reset();
        for (int i = 0; i < 3; i++) alloc_one(pcs[i], 1'b1, 1'b1, 1'b1);
        for (int i = 2; i >= 0; i--) begin
            resolve_one(PB'(i), 1'b1);
            n_checks++; if (uv !== 1'b0) begin n_fail++; $display("FAIL ooo_premature: got %0b expected 0 after resolve %0d", uv, i); end
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++; if (uv !== 1'b1 || upc !== pcs[i]) begin n_fail++; $display("FAIL ooo_order: got v=%0b pc=%h expected 1/%h", uv, upc, pcs[i]); end
        end
        cycle();
        n_checks++; if (uv !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL ooo_drain: got v=%0b empty=%0b expected 0/1", uv, empty); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) alloc_one(32'h300 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        flush_valid = 1'b1; flush_tag = PB'(1);
        cycle();
        flush_valid = 1'b0;
        alloc_valid = 1'b1; alloc_pc = 32'h400;
        #1;
        n_checks++; if (alloc_tag !== PB'(2) || alloc_ready !== 1'b1) begin n_fail++; $display("FAIL flush_tail: got tag %0d ready %0b expected 2/1", alloc_tag, alloc_ready); end
        cycle();
        alloc_valid = 1'b0;
        resolve_one(PB'(3), 1'b1);
        n_checks++; if (mis !== 1'b0) begin n_fail++; $display("FAIL flush_stale_resolve: got %0b expected 0", mis); end
        for (int i = 0; i < 13; i++) alloc_one($urandom, 1'b0, 1'b0, 1'b0);
        n_checks++; if (alloc_ready !== 1'b0 || uv !== 1'b0) begin n_fail++; $display("FAIL flush_count: got ready %0b uv %0b expected 0/0", alloc_ready, uv); end
    endtask

    task automatic test_wrap_flush_all();
        bit   saw_wrap;
        int   last_tag;
        ent_t e;
        do_reset();
        saw_wrap = 0;
        last_tag = -1;
        for (int c = 0; c < 56; c++) begin
            idle_inputs();
            alloc_valid = 1'b1; alloc_pc = $urandom; alloc_g = 1'($urandom);
            alloc_b = 1'($urandom); alloc_sel = 1'($urandom);
            foreach (mq[k]) if (!mq[k].res && !resolve_valid) begin
                resolve_valid = 1'b1; resolve_tag = mq[k].tag; resolve_taken = 1'($urandom);
            end
            #1;
            n_checks++; if (alloc_tag !== PB'(m_tail)) begin n_fail++; $display("FAIL wrap_tag: got %0d expected %0d", alloc_tag, m_tail); end
            if (alloc_ready && alloc_tag == PB'(0) && last_tag == DEPTH - 1) saw_wrap = 1;
            if (alloc_ready) last_tag = int'(alloc_tag);
            cycle();
            n_checks++; if (uv !== e_uv || (e_uv && upc !== e_upc)) begin n_fail++; $display("FAIL wrap_update: got v=%0b pc=%h expected %0b/%h", uv, upc, e_uv, e_upc); end
            n_checks++; if (mis !== e_mis) begin n_fail++; $display("FAIL wrap_mis: got %0b expected %0b", mis, e_mis); end
        end
        n_checks++; if (saw_wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_seen: got %0b expected 1", saw_wrap); end
        idle_inputs();
        e = mq[mq.size() - 1];
        flush_all = 1'b1;
        resolve_valid = 1'b1; resolve_tag = e.tag;
        resolve_taken = !(e.sel ? e.g : e.b);
        cycle();
        flush_all = 1'b0; resolve_valid = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL flush_all_empty: got %0b expected 1", empty); end
        n_checks++; if (mis !== 1'b0 || uv !== 1'b0) begin n_fail++; $display("FAIL flush_all_quiet: got mis %0b uv %0b expected 0/0", mis, uv); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) alloc_one(32'h500 + 32'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 3; i < 6; i++) resolve_one(PB'(i), 1'b1);
        rst = 1'b1; alloc_valid = 1'b1; resolve_valid = 1'b1; resolve_tag = PB'(0); resolve_taken = 1'b1;
        cycle();
        idle_inputs();
        rst = 1'b0;
        #1;
        n_checks++; if ({mis, mis_tag, uv, upc, ut, ugc, ubc} !== '0) begin n_fail++; $display("FAIL midrst_outputs: got mis %0b uv %0b pc %h expected all 0", mis, uv, upc); end
        n_checks++; if (empty !== 1'b1 || alloc_tag !== PB'(0)) begin n_fail++; $display("FAIL midrst_state: got empty %0b tag %0d expected 1/0", empty, alloc_tag); end
        cycle();
        n_checks++; if (uv !== 1'b0) begin n_fail++; $display("FAIL midrst_no_update: got %0b expected 0", uv); end
    endtask

    task automatic test_random();
        bit exp_ready;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            idle_inputs();
            rst         = ($urandom_range(0, 199) == 0);
            flush_all   = ($urandom_range(0, 79) == 0);
            alloc_valid = ($urandom_range(0, 9) < 6);
            alloc_pc    = $urandom;
            alloc_g     = 1'($urandom);
            alloc_b     = 1'($urandom);
            alloc_sel   = 1'($urandom);
            if ($urandom_range(0, 9) < 7) begin
                resolve_valid = 1'b1;
                resolve_taken = 1'($urandom);
                if (mq.size() > 0 && $urandom_range(0, 3) != 0) resolve_tag = mq[$urandom_range(0, mq.size() - 1)].tag;
                else resolve_tag = PB'($urandom);
            end
            if ($urandom_range(0, 24) == 0) begin
                flush_valid = 1'b1;
                if (mq.size() > 0 && $urandom_range(0, 3) != 0) flush_tag = mq[$urandom_range(0, mq.size() - 1)].tag;
                else flush_tag = PB'($urandom);
            end
            exp_ready = !rst && !flush_valid && !flush_all && (mq.size() < DEPTH);
            #1;
            n_checks++; if (alloc_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready: got %0b expected %0b cycle %0d", alloc_ready, exp_ready, c); end
            n_checks++; if (alloc_tag !== PB'(m_tail)) begin n_fail++; $display("FAIL rnd_tag: got %0d expected %0d cycle %0d", alloc_tag, m_tail, c); end
            n_checks++; if (empty !== (mq.size() == 0)) begin n_fail++; $display("FAIL rnd_empty: got %0b expected %0b cycle %0d", empty, mq.size() == 0, c); end
            cycle();
            n_checks++; if (mis !== e_mis || (e_mis && mis_tag !== e_mis_tag)) begin n_fail++; $display("FAIL rnd_mis: got %0b/%0d expected %0b/%0d cycle %0d", mis, mis_tag, e_mis, e_mis_tag, c); end
            n_checks++; if (uv !== e_uv) begin n_fail++; $display("FAIL rnd_uv: got %0b expected %0b cycle %0d", uv, e_uv, c); end
            if (e_uv) begin
                n_checks++; if ({upc, ut, ugc, ubc} !== {e_upc, e_ut, e_ugc, e_ubc}) begin n_fail++; $display("FAIL rnd_packet: got %h/%b expected %h/%b cycle %0d", upc, {ut, ugc, ubc}, e_upc, {e_ut, e_ugc, e_ubc}, c); end
            end
        end
`ifdef BPQ_STATS_EN
        n_checks++; if (stat_ret !== 32'(m_ret)) begin n_fail++; $display("FAIL stat_retired: got %0d expected %0d", stat_ret, m_ret); end
        n_checks++; if (stat_mis !== 32'(m_misc)) begin n_fail++; $display("FAIL stat_mispredict: got %0d expected %0d", stat_mis, m_misc); end
        n_checks++; if (stat_sel !== 32'(m_sel)) begin n_fail++; $display("FAIL stat_sel_gshare: got %0d expected %0d", stat_sel, m_sel); end
`endif
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_fill();
        test_mispredict();
        test_out_of_order();
        test_flush();
        test_wrap_flush_all();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predict_queue.md
Name: branch_predict_queue

Overview:
- In-order queue of in-flight conditional-branch predictions, sitting directly downstream of the tournament selector.
- At predict time it records the GShare prediction, the Bimodal prediction, the selector's choice and the PC.
- At branch resolution it flags mispredicts. At in-order retirement it produces the training packet (taken, gshare_correct, bimodal_correct) consumed by the selector's and predictors' update ports.

Parameters:
- DEPTH, 16, number of entries; power of two, minimum 4.
- PTR_BITS, 4, log2(DEPTH); width of tags and pointers.

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- alloc_valid_i  input  1  new prediction to record.
- alloc_ready_o  output  1  queue can accept an allocation.
- alloc_pc_i  input  32  branch PC.
- alloc_gshare_pred_i  input  1  GShare direction.
- alloc_bimodal_pred_i  input  1  Bimodal direction.
- alloc_select_gshare_i  input  1  selector chose GShare.
- alloc_tag_o  output  PTR_BITS  tag assigned to the current allocation (tail pointer).
- resolve_valid_i  input  1  branch resolved.
- resolve_tag_i  input  PTR_BITS  entry being resolved.
- resolve_taken_i  input  1  actual direction.
- flush_valid_i  input  1  squash entries younger than flush_tag_i.
- flush_tag_i  input  PTR_BITS  youngest surviving entry.
- flush_all_i  input  1  empty the queue.
- mispredict_o  output  1  final prediction differed from actual.
- mispredict_tag_o  output  PTR_BITS  tag of the mispredicted entry.
- update_valid_o  output  1  retire/training packet valid.
- update_pc_o  output  32  retired branch PC.
- update_taken_o  output  1  actual direction.
- update_gshare_correct_o  output  1  GShare prediction equals actual.
- update_bimodal_correct_o  output  1  Bimodal prediction equals actual.
- empty_o  output  1  count == 0.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous, active-high.
- Reset: head, tail and count go to 0, and all entry valid/resolved bits clear. All registered outputs go to 0 (mispredict_o, mispredict_tag_o, update_*). empty_o is 1.
- State:
  - count is PTR_BITS+1 bits wide.
  - Each entry holds: valid, resolved, taken, pc, gshare_pred, bimodal_pred, sel_gshare.
  - Pointers wrap modulo DEPTH.
- alloc_ready_o = !rst && !flush_valid_i && !flush_all_i && count < DEPTH. It is combinational from registered state and does not depend on a same-cycle retire.
- Allocation: occurs when alloc_valid_i && alloc_ready_o. The entry is written at tail with valid=1 and resolved=0. alloc_tag_o = tail. Tail increments and count increments.
- Resolution:
  - If resolve_valid_i is high and entry[resolve_tag_i] is valid and unresolved, set resolved=1 and store taken.
  - One cycle later: mispredict_o = taken XOR final_pred, where final_pred = sel_gshare ? gshare_pred : bimodal_pred. mispredict_tag_o = resolve_tag_i.
  - A resolve to an invalid or already-resolved entry is ignored, and mispredict_o is 0.
- Retirement:
  - If the head entry is valid and resolved at the start of the cycle, it pops: valid clears, head increments, count decrements.
  - Next cycle: update_valid_o=1, update_pc_o=pc, update_taken_o=taken, update_gshare_correct_o=(gshare_pred==taken), update_bimodal_correct_o=(bimodal_pred==taken).
  - At most one retire per cycle.
  - A resolve and a retire of the same entry cannot happen in the same cycle, because retire samples the registered resolved bit. The minimum resolve-to-update latency is 2 cycles.
- Flush:
  - flush_valid_i with a valid flush_tag_i invalidates every entry strictly younger than flush_tag_i.
  - tail becomes flush_tag_i+1. count becomes ((flush_tag_i - head) mod DEPTH) + 1, minus 1 if a retire also occurs that cycle.
  - flush_tag_i pointing at an invalid entry: the flush is ignored.
  - A same-cycle resolve targeting a squashed entry is dropped (no mispredict_o).
  - A same-cycle retire of the head proceeds normally.
- flush_all_i: takes priority over flush_valid_i and resolve. Clears all valid bits and sets head=tail=count=0. No retire occurs that cycle, and mispredict_o is 0 next cycle.
- Priority per cycle: rst > flush_all_i > flush_valid_i > (resolve, retire, alloc).
- Wrap-around: tags are raw indices; valid bits disambiguate. Full is count==DEPTH; empty is count==0.

Optional Feature:
- Macro: BPQ_STATS_EN.
- When defined:
  - Adds outputs stat_retired_o [31:0], stat_mispredict_o [31:0] and stat_sel_gshare_o [31:0].
  - Each output is a free-running, wrap-around counter of retires, of reported mispredicts, and of retires whose entry had sel_gshare=1.
  - All three clear on rst and hold across flushes.
- When undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset, then allocate 16 entries back-to-back -> tags 0..15, alloc_ready_o=0 after the 16th, empty_o=0; a 17th alloc_valid_i is not accepted.
- Alloc PC 0x100 with gshare=1, bimodal=0, sel_gshare=0, then resolve tag 0 taken=1 -> next cycle mispredict_o=1, tag 0. One cycle later update_valid_o=1, pc 0x100, taken=1, gshare_correct=1, bimodal_correct=0.
- Allocate tags 0..2, resolve 2 then 1 then 0 -> no update until tag 0 resolves; then three consecutive update_valid_o cycles in order for PCs of tags 0, 1, 2.
- Fill to count 5 (tags 0..4), flush_tag_i=1 -> count=2, the next alloc gets tag 2, and a later resolve of the old tag 3 is ignored.
- Fill to 16 and retire through, wrapping the tail to tag 0 -> entries reuse tags and update ordering is preserved. Then flush_all_i with a simultaneous resolve -> empty_o=1 and no mispredict_o.
- Assert rst mid-operation with 6 entries, 3 of them resolved -> all outputs 0 next cycle, no update packets, alloc tag restarts at 0.
